// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared definitions for the sequential ALU.
//   - 5-bit opcode encodings (single-cycle set 0x00-0x0F, divide set 0x10-0x14)
//   - control FSM state encoding
//   - is_multicycle(): true for opcodes that run through the iterative divider
package alu_seq_pkg;

  localparam logic [4:0] OP_OR     = 5'h00;
  localparam logic [4:0] OP_AND    = 5'h01;
  localparam logic [4:0] OP_XOR    = 5'h02;
  localparam logic [4:0] OP_ADD    = 5'h03;
  localparam logic [4:0] OP_SUB    = 5'h04;
  localparam logic [4:0] OP_SHL    = 5'h05;
  localparam logic [4:0] OP_SHR    = 5'h06;
  localparam logic [4:0] OP_NOTA   = 5'h07;
  localparam logic [4:0] OP_MULS   = 5'h08;
  localparam logic [4:0] OP_MULU   = 5'h09;
  localparam logic [4:0] OP_SLT    = 5'h0A;
  localparam logic [4:0] OP_SLTU   = 5'h0B;
  localparam logic [4:0] OP_LOAD   = 5'h0C;
  localparam logic [4:0] OP_LOADHI = 5'h0D;
  localparam logic [4:0] OP_SHRS   = 5'h0E;
  localparam logic [4:0] OP_FPMULS = 5'h0F;
  localparam logic [4:0] OP_DIVS   = 5'h10;
  localparam logic [4:0] OP_DIVU   = 5'h11;
  localparam logic [4:0] OP_MODS   = 5'h12;
  localparam logic [4:0] OP_MODU   = 5'h13;
  localparam logic [4:0] OP_FPDIVS = 5'h14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_t;

  function automatic logic is_multicycle(input logic [4:0] op);
    return (op >= OP_DIVS) && (op <= OP_FPDIVS);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring unsigned divider, one quotient bit per step.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears all state)
//   load        - capture dividend/divisor and clear the partial remainder
//   step        - perform one restoring iteration
//   dividend    - DVD_W-bit dividend, consumed MSB first
//   divisor     - DVS_W-bit divisor
//   quotient    - low DVS_W bits of the quotient built so far
//   remainder   - current partial remainder (final after the last step)
// The dividend register doubles as the quotient register: dividend bits leave
// at the top while quotient bits enter at the bottom. Running fewer than DVD_W
// steps therefore divides only the top bits of the dividend.
module alu_divider #(
  parameter int DVD_W = 48,
  parameter int DVS_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVS_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder
);

  logic [DVD_W-1:0] dq;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  logic [DVS_W:0]   trial;
  logic [DVS_W:0]   diff;

  // rem < dvs is invariant, so the shifted trial value fits in DVS_W+1 bits
  // and a non-negative difference always fits back into DVS_W bits.
  always_comb begin
    trial = {rem, dq[DVD_W-1]};
    diff  = trial - {1'b0, dvs};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dq  <= '0;
      rem <= '0;
      dvs <= '0;
    end else if (load) begin
      dq  <= dividend;
      rem <= '0;
      dvs <= divisor;
    end else if (step) begin
      if (!diff[DVS_W]) begin
        rem <= diff[DVS_W-1:0];
        dq  <= {dq[DVD_W-2:0], 1'b1};
      end else begin
        rem <= trial[DVS_W-1:0];
        dq  <= {dq[DVD_W-2:0], 1'b0};
      end
    end
  end

  assign quotient  = dq[DVS_W-1:0];
  assign remainder = rem;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU for the CPU execute stage.
// Single-cycle ops (0x00-0x0F, 0x15-0x1F) complete one cycle after start;
// divide ops (0x10-0x14) run through an iterative divider and hold busy high.
// Ports:
//   clk     - clock, all state on rising edge
//   reset   - synchronous, active-high
//   start   - operation request, accepted only when busy=0
//   opcode  - operation select
//   a, b    - operands, sampled at an accepted start
//   y       - result register, holds until the next completion
//   done    - one-cycle pulse when y is updated
//   busy    - high while a divide is in progress
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             done,
  output logic             busy
);

  localparam int DW    = WIDTH + FRAC;
  localparam int PW    = WIDTH + FRAC;
  localparam int CNT_W = $clog2(DW + 1);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int HALF  = WIDTH / 2;
  localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [4:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic             a_neg, b_neg, b_zero;
  logic             div_load, div_step, fix_done, single_acc;

  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] div_q, div_r, div_y;

  logic signed [PW-1:0] a_ext, b_ext, prod;
  logic                 shift_big;
  logic [WIDTH-1:0]     alu_y;

  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  assign busy = (state != IDLE);

  // Operand conditioning: signed divides work on magnitudes; the dividend sits
  // left-aligned so WIDTH steps give a/b and WIDTH+FRAC steps give (a<<FRAC)/b.
  always_comb begin
    signed_op = (opcode != OP_DIVU) && (opcode != OP_MODU);
    a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  alu_divider #(
    .DVD_W (DW),
    .DVS_W (WIDTH)
  ) u_div (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  ({a_mag, {FRAC{1'b0}}}),
    .divisor   (b_mag),
    .quotient  (div_q),
    .remainder (div_r)
  );

  // Single-cycle datapath. The product only needs WIDTH+FRAC bits: the low
  // WIDTH bits serve MULS/MULU, bits [WIDTH+FRAC-1:FRAC] serve FPMULS.
  always_comb begin
    a_ext     = {{FRAC{a[WIDTH-1]}}, a};
    b_ext     = {{FRAC{b[WIDTH-1]}}, b};
    prod      = a_ext * b_ext;
    shift_big = (b >= SHIFT_LIM);
    alu_y     = '0;
    case (opcode)
      OP_OR:     alu_y = a | b;
      OP_AND:    alu_y = a & b;
      OP_XOR:    alu_y = a ^ b;
      OP_ADD:    alu_y = a + b;
      OP_SUB:    alu_y = a - b;
      OP_SHL:    alu_y = shift_big ? '0 : (a << b[SH_W-1:0]);
      OP_SHR:    alu_y = shift_big ? '0 : (a >> b[SH_W-1:0]);
      OP_NOTA:   alu_y = ~a;
      OP_MULS,
      OP_MULU:   alu_y = prod[WIDTH-1:0];
      OP_SLT:    alu_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:   alu_y = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_LOAD:   alu_y = b;
      OP_LOADHI: alu_y = {b[HALF-1:0], a[HALF-1:0]};
      OP_SHRS:   alu_y = shift_big ? {WIDTH{a[WIDTH-1]}} : ($signed(a) >>> b[SH_W-1:0]);
      OP_FPMULS: alu_y = prod[WIDTH+FRAC-1:FRAC];
      default:   alu_y = '0;
    endcase
  end

  // Sign correction of the unsigned divider result. Divide-by-zero overrides
  // the raw divider output; most-negative / -1 falls out of the magnitude path.
  always_comb begin
    div_y = '0;
    case (op_r)
      OP_DIVS,
      OP_FPDIVS: div_y = b_zero ? '1  : neg_if(div_q, a_neg ^ b_neg);
      OP_DIVU:   div_y = b_zero ? '1  : div_q;
      OP_MODS:   div_y = b_zero ? a_r : neg_if(div_r, a_neg);
      OP_MODU:   div_y = b_zero ? a_r : div_r;
      default:   div_y = '0;
    endcase
  end

  // Control FSM: next state and strobes
  always_comb begin
    state_next = state;
    div_load   = 1'b0;
    div_step   = 1'b0;
    fix_done   = 1'b0;
    single_acc = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_multicycle(opcode)) begin
            div_load   = 1'b1;
            state_next = DIV;
          end else begin
            single_acc = 1'b1;
          end
        end
      end
      DIV: begin
        div_step = 1'b1;
        if (cnt == CNT_W'(1)) state_next = FIX;
      end
      FIX: begin
        fix_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered state, operand side-information and result
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      b_zero <= 1'b0;
      y      <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      if (div_load) begin
        cnt    <= (opcode == OP_FPDIVS) ? CNT_W'(DW) : CNT_W'(WIDTH);
        op_r   <= opcode;
        a_r    <= a;
        a_neg  <= signed_op & a[WIDTH-1];
        b_neg  <= signed_op & b[WIDTH-1];
        b_zero <= (b == '0);
      end else if (div_step) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (fix_done) begin
        y    <= div_y;
        done <= 1'b1;
      end else if (single_acc) begin
        y    <= alu_y;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq (WIDTH=32, FRAC=16)
// against an arithmetic reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] op_a, op_b;
  logic [31:0] y;
  logic        done, busy;

  int ncomp = 0;
  int nfail = 0;

  alu_seq #(.WIDTH(32), .FRAC(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .a      (op_a),
    .b      (op_b),
    .y      (y),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model: plain 64-bit integer arithmetic on the operand values.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] z);
    longint sx, sz, ux, uz, r;
    sx = longint'($signed(x));
    sz = longint'($signed(z));
    ux = longint'({32'h0, x});
    uz = longint'({32'h0, z});
    r  = 0;
    case (op)
      OP_OR:     r = ux | uz;
      OP_AND:    r = ux & uz;
      OP_XOR:    r = ux ^ uz;
      OP_ADD:    r = ux + uz;
      OP_SUB:    r = ux - uz;
      OP_SHL:    r = (uz >= 32) ? 0 : (ux << uz);
      OP_SHR:    r = (uz >= 32) ? 0 : (ux >> uz);
      OP_NOTA:   r = ~ux;
      OP_MULS:   r = sx * sz;
      OP_MULU:   r = ux * uz;
      OP_SLT:    r = (sx < sz) ? 1 : 0;
      OP_SLTU:   r = (ux < uz) ? 1 : 0;
      OP_LOAD:   r = uz;
      OP_LOADHI: r = ((uz & 64'hFFFF) << 16) | (ux & 64'hFFFF);
      OP_SHRS:   r = sx >>> ((uz >= 32) ? 32 : uz);
      OP_FPMULS: r = (sx * sz) >>> 16;
      OP_DIVS:   r = (z == 0) ? -1 : sx / sz;
      OP_DIVU:   r = (z == 0) ? -1 : ux / uz;
      OP_MODS:   r = (z == 0) ? sx : sx % sz;
      OP_MODU:   r = (z == 0) ? ux : ux % uz;
      OP_FPDIVS: r = (z == 0) ? -1 : (sx * 65536) / sz;
      default:   r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic int latency(input logic [4:0] op);
    if (op == OP_FPDIVS) return 32 + 16 + 2;
    if (op >= OP_DIVS && op <= OP_MODU) return 32 + 2;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for its done pulse.
  // now=1 drives start in the current cycle (used right after a done pulse).
  // intrude>0 pulses a start of ADD at that cycle count while busy.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] x,
                       input logic [31:0] z, input bit now, input int intrude);
    logic [31:0] exp;
    int          cycles;
    bit          mc;
    exp = model(op, x, z);
    mc  = (latency(op) > 1);
    if (!now) @(negedge clk);
    start = 1'b1; opcode = op; op_a = x; op_b = z;
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom; opcode = 5'($urandom);
    chk($sformatf("%s busy_after_start", tag), {31'b0, busy}, {31'b0, mc});
    cycles = 1;
    while (done !== 1'b1 && cycles < 200) begin
      if (cycles == intrude) begin
        start = 1'b1; opcode = OP_ADD;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    chk($sformatf("%s latency", tag), 32'(cycles), 32'(latency(op)));
    chk($sformatf("%s y", tag), y, exp);
    chk($sformatf("%s busy_at_done", tag), {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int dcount;
    reset = 1'b1; start = 1'b0; opcode = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    chk("reset y", y, 32'h0);
    chk("reset done", {31'b0, done}, 32'h0);
    chk("reset busy", {31'b0, busy}, 32'h0);
    reset = 1'b0;

    do_op("add_wrap",  OP_ADD,    32'hFFFFFFFF, 32'h1, 1'b0, 0);
    do_op("divs_m7_2", OP_DIVS,   32'hFFFFFFF9, 32'h2, 1'b0, 0);
    chk("divs_m7_2 value", y, 32'hFFFFFFFD);
    do_op("mods_m7_2", OP_MODS,   32'hFFFFFFF9, 32'h2, 1'b0, 0);
    chk("mods_m7_2 value", y, 32'hFFFFFFFF);
    do_op("divu_by0",  OP_DIVU,   32'd100, 32'h0, 1'b0, 0);
    chk("divu_by0 value", y, 32'hFFFFFFFF);
    do_op("modu_by0",  OP_MODU,   32'd100, 32'h0, 1'b0, 0);
    chk("modu_by0 value", y, 32'd100);
    do_op("divs_ovf",  OP_DIVS,   32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    chk("divs_ovf value", y, 32'h80000000);
    do_op("mods_ovf",  OP_MODS,   32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    do_op("divs_by0",  OP_DIVS,   32'hFFFFFFFB, 32'h0, 1'b0, 0);
    do_op("mods_by0",  OP_MODS,   32'hFFFFFFFB, 32'h0, 1'b0, 0);
    do_op("fpdivs",    OP_FPDIVS, 32'h00030000, 32'h00020000, 1'b0, 0);
    chk("fpdivs value", y, 32'h00018000);
    do_op("fpdivs_neg", OP_FPDIVS, 32'hFFFD0000, 32'h00020000, 1'b0, 0);
    do_op("fpdivs_by0", OP_FPDIVS, 32'h00050000, 32'h0, 1'b0, 0);

    do_op("divu_intrude", OP_DIVU, 32'd1000003, 32'd17, 1'b0, 5);
    do_op("add_b2b", OP_ADD, 32'h12345678, 32'h11111111, 1'b1, 0);
    do_op("divu_b2b", OP_DIVU, 32'hDEADBEEF, 32'd3, 1'b1, 0);

    do_op("shrs_big", OP_SHRS,   32'h80000000, 32'd40, 1'b0, 0);
    chk("shrs_big value", y, 32'hFFFFFFFF);
    do_op("shl_32",   OP_SHL,    32'hFFFFFFFF, 32'd32, 1'b0, 0);
    do_op("shr_31",   OP_SHR,    32'h80000000, 32'd31, 1'b0, 0);
    do_op("loadhi",   OP_LOADHI, 32'hAAAA1234, 32'hBBBB5678, 1'b0, 0);
    do_op("slt",      OP_SLT,    32'hFFFFFFFF, 32'h1, 1'b0, 0);
    do_op("op_1a",    5'h1A,     32'h1234, 32'h5678, 1'b0, 0);
    do_op("fpmuls",   OP_FPMULS, 32'h00018000, 32'hFFFE0000, 1'b0, 0);
    chk("fpmuls value", y, 32'hFFFD0000);

    // Reset in the middle of a divide: aborted, no done pulse, y cleared.
    @(negedge clk);
    start = 1'b1; opcode = OP_DIVS; op_a = 32'd999; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("rst_mid busy_before", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid y", y, 32'h0);
    chk("rst_mid busy", {31'b0, busy}, 32'h0);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("rst_mid done_pulses", 32'(dcount), 32'h0);
    do_op("after_rst", OP_DIVU, 32'd999, 32'd7, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [4:0]  rop;
      logic [31:0] ra, rb;
      rop = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(16, 20)) : 5'($urandom_range(0, 31));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'($urandom_range(0, 40));
        1: rb = 32'h0;
        2: ra = 32'h80000000;
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      do_op($sformatf("rnd%0d_op%0h", i, rop), rop, ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised sequential successor to the CPU's single-cycle ALU. Keeps the full 16-op combinational set and adds iterative divide, modulo and fixed-point divide behind a start/busy/done handshake. Sits in the CPU execute stage. The stage stalls while busy is high.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, even)
FRAC, 16, fractional bits for fixed-point ops (0 < FRAC < WIDTH)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
start  in  1  operation request; accepted only when busy=0
opcode  in  5  operation select (see Behaviour)
a  in  WIDTH  operand A, sampled at accepted start
b  in  WIDTH  operand B, sampled at accepted start
y  out  WIDTH  result register; holds until next completion
done  out  1  one-cycle pulse when y is updated
busy  out  1  high while a multi-cycle op is in progress

Behaviour:
- Reset values: y=0, done=0, busy=0, FSM=IDLE, divider state cleared. Reset mid-divide aborts with no done pulse.
- Opcodes 0x00-0x0F: OR, AND, XOR, ADD, SUB, SHL, SHR, NOTA, MULS, MULU, SLT, SLTU, LOAD, LOADHI, SHRS, FPMULS. Encodings and semantics match the existing ALU, generalised to WIDTH:
  - MUL ops: low WIDTH bits of the product.
  - LOADHI: y = {b[WIDTH/2-1:0], a[WIDTH/2-1:0]}.
  - FPMULS: bits [WIDTH+FRAC-1:FRAC] of the 2*WIDTH signed product.
  - Shifts use the full unsigned b. b>=WIDTH gives 0 (SHL/SHR) or WIDTH copies of a[WIDTH-1] (SHRS).
- Single-cycle ops: start accepted in cycle N gives y updated and done=1 in cycle N+1. busy stays 0.
- Multi-cycle ops:
  - 0x10 DIVS: signed quotient, truncates toward zero.
  - 0x11 DIVU: unsigned quotient.
  - 0x12 MODS: signed remainder; sign follows a.
  - 0x13 MODU: unsigned remainder.
  - 0x14 FPDIVS: signed (a<<FRAC)/b; low WIDTH bits of the quotient.
- Opcodes 0x15-0x1F: single-cycle, y=0.
- FSM:
  - IDLE -> DIV on start with a divide opcode. busy=1 from cycle N+1.
  - DIV iterates one quotient bit per cycle: WIDTH iterations, or WIDTH+FRAC for FPDIVS.
  - DIV -> FIX: one cycle for sign correction.
  - FIX -> IDLE: y written, done=1, busy=0 in that same cycle.
  - Total latency start->done: WIDTH+2 cycles (FPDIVS: WIDTH+FRAC+2).
- start while busy=1 is ignored: no queuing, operands not sampled.
- start in the same cycle as done (busy=0) is accepted normally, giving back-to-back operation.
- Divide-by-zero:
  - Quotient: all ones (DIVU) or -1 (DIVS, FPDIVS).
  - Remainder: a.
  - Full latency is still taken.
- Signed overflow (a = most-negative, b = -1): quotient = most-negative, remainder = 0.
- Signed ops: magnitudes are divided unsigned. The quotient is negated if sign(a) != sign(b); the remainder is negated if a<0.
- Operand inputs may change freely after acceptance.

Decomposition:
- Package alu_seq_pkg:
  - 5-bit opcode localparams OP_OR..OP_FPDIVS.
  - FSM state encoding IDLE/DIV/FIX.
  - Helper function is_multicycle(opcode).
- Sub-module alu_divider: iterative restoring unsigned divider, parametrised on dividend width (WIDTH+FRAC), with load/step/quotient/remainder ports.
- The top level handles sign pre/post-processing, single-cycle ops and the FSM.

Test Plan:
- WIDTH=32, ADD a=0xFFFFFFFF b=1 -> y=0, done=1 exactly 1 cycle after start, busy never high.
- DIVS a=-7 b=2 -> y=-3 (0xFFFFFFFD), done exactly 34 cycles after start. MODS with the same operands -> y=-1.
- DIVU a=100 b=0 -> y=0xFFFFFFFF. MODU a=100 b=0 -> y=100. DIVS a=0x80000000 b=-1 -> y=0x80000000.
- FPDIVS a=0x00030000 b=0x00020000 -> y=0x00018000 (1.5), done after 50 cycles.
- Start DIVU, pulse start with ADD while busy -> ADD ignored, y = quotient. Assert reset at cycle 10 of a divide -> y=0, busy=0, no done pulse. Also: start ADD in the done cycle -> ADD result exactly 1 cycle later.
- SHRS a=0x80000000 b=40 -> y=0xFFFFFFFF. SHL b=32 -> 0. FPMULS 0x00018000*0xFFFE0000 -> 0xFFFD0000 (1.5*-2 = -3).
